// File: rtl/intirvx_wb_arbiter_pkg.sv
// Shared types and constants for the integer writeback arbiter: FSM states,
// source indices and the CPU-level defaults for data width and flush length.
package intirvx_wb_arbiter_pkg;

    localparam int CPU_XLEN         = 32;
    localparam int CPU_FLUSH_CYCLES = 2;
    localparam int FLUSH_CNT_W      = 4;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;

    typedef enum logic {
        WB_RUN   = 1'b0,
        WB_FLUSH = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [CPU_XLEN-1:0] data;
        logic [4:0]          rd;
    } wb_req_t;

endpackage

// File: rtl/intirvx_rr_arb2.sv
// Two-input round-robin arbiter. Remembers the last granted source and
// favours the other one when both request in the same cycle.
module intirvx_rr_arb2
    import intirvx_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[SRC_ALU] && req_i[SRC_LSU]) begin
            gnt_o[~last_q] = 1'b1;
        end else begin
            gnt_o = req_i;
        end
    end

    // Every grant is a completed transfer, so the pointer tracks grants directly.
    always_comb begin
        last_d = last_q;
        if (gnt_o[SRC_ALU]) begin
            last_d = 1'(SRC_ALU);
        end else if (gnt_o[SRC_LSU]) begin
            last_d = 1'(SRC_LSU);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'(SRC_LSU);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/intirvx_wb_arbiter.sv
// Integer writeback arbiter: shares the register-file write port between ALU
// and LSU, and turns taken ALU jumps into a PC redirect plus a timed flush.
module intirvx_wb_arbiter
    import intirvx_wb_arbiter_pkg::*;
#(
    parameter int XLEN         = CPU_XLEN,
    parameter int FLUSH_CYCLES = CPU_FLUSH_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] alu_result,
    input  logic [4:0]      alu_rd,
    input  logic            alu_jump,
    input  logic [XLEN-1:0] alu_jump_addr,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [XLEN-1:0] lsu_result,
    input  logic [4:0]      lsu_rd,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_redirect_addr,
    output logic            flush,
    output logic            wb_busy
);

    localparam logic [FLUSH_CNT_W-1:0] CNT_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    wb_state_e              state_q;
    logic [FLUSH_CNT_W-1:0] cnt_q;
    logic                   rf_we_q;
    logic [4:0]             rf_waddr_q;
    logic [XLEN-1:0]        rf_wdata_q;
    logic                   pc_redirect_q;
    logic [XLEN-1:0]        pc_redirect_addr_q;
    logic                   flush_q;

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            xfer;
    logic            jump_xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    // Handshake: a source transfers in any cycle where its valid and ready are
    // both high. ready is combinational from state, valids and the RR pointer,
    // is never raised without valid, and at most one source is ready per cycle.
    // The ALU is masked off during FLUSH because its FIFO is being discarded.
    assign req[SRC_ALU] = alu_valid && (state_q == WB_RUN);
    assign req[SRC_LSU] = lsu_valid;

    intirvx_rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign alu_ready = gnt[SRC_ALU];
    assign lsu_ready = gnt[SRC_LSU];
    assign xfer      = |gnt;
    assign jump_xfer = gnt[SRC_ALU] && alu_jump;
    assign sel_rd    = gnt[SRC_ALU] ? alu_rd : lsu_rd;
    assign sel_data  = gnt[SRC_ALU] ? alu_result : lsu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= WB_RUN;
            cnt_q              <= '0;
            rf_we_q            <= 1'b0;
            rf_waddr_q         <= '0;
            rf_wdata_q         <= '0;
            pc_redirect_q      <= 1'b0;
            pc_redirect_addr_q <= '0;
            flush_q            <= 1'b0;
        end else begin
            // x0 is hardwired: the entry retires but nothing is written.
            rf_we_q <= xfer && (sel_rd != 5'd0);
            if (xfer && (sel_rd != 5'd0)) begin
                rf_waddr_q <= sel_rd;
                rf_wdata_q <= sel_data;
            end

            pc_redirect_q <= jump_xfer;
            if (jump_xfer) begin
                pc_redirect_addr_q <= alu_jump_addr;
            end

            case (state_q)
                WB_RUN: begin
                    if (jump_xfer) begin
                        state_q <= WB_FLUSH;
                        cnt_q   <= CNT_INIT;
                        flush_q <= 1'b1;
                    end
                end
                WB_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= WB_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= WB_RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign rf_we            = rf_we_q;
    assign rf_waddr         = rf_waddr_q;
    assign rf_wdata         = rf_wdata_q;
    assign pc_redirect      = pc_redirect_q;
    assign pc_redirect_addr = pc_redirect_addr_q;
    assign flush            = flush_q;
    assign wb_busy          = (state_q == WB_FLUSH);

endmodule

// File: tb/tb_intirvx_wb_arbiter.sv
// Directed bench for intirvx_wb_arbiter: expected writebacks are queued when a
// transfer is driven and compared one cycle later.
module tb_intirvx_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_result;
    logic [4:0]  alu_rd;
    logic        alu_jump;
    logic [31:0] alu_jump_addr;
    logic        alu_valid;
    logic        alu_ready;
    logic [31:0] lsu_result;
    logic [4:0]  lsu_rd;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_redirect;
    logic [31:0] pc_redirect_addr;
    logic        flush;
    logic        wb_busy;

    int errors = 0;
    int checks = 0;

    // Each entry: {we, rd, data}; rd/data are only meaningful when we = 1.
    logic [37:0] exp_q[$];

    intirvx_wb_arbiter #(
        .XLEN         (32),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alu_result       (alu_result),
        .alu_rd           (alu_rd),
        .alu_jump         (alu_jump),
        .alu_jump_addr    (alu_jump_addr),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .lsu_result       (lsu_result),
        .lsu_rd           (lsu_rd),
        .lsu_valid        (lsu_valid),
        .lsu_ready        (lsu_ready),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .pc_redirect      (pc_redirect),
        .pc_redirect_addr (pc_redirect_addr),
        .flush            (flush),
        .wb_busy          (wb_busy)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                         input logic aj, input logic [31:0] ajaddr,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] lres);
        alu_valid     = av;
        alu_rd        = ard;
        alu_result    = ares;
        alu_jump      = aj;
        alu_jump_addr = ajaddr;
        lsu_valid     = lv;
        lsu_rd        = lrd;
        lsu_result    = lres;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Called just after a rising edge with inputs driven. Checks combinational
    // readies and registered status mid-cycle, scores last cycle's writeback,
    // then queues the writeback this cycle's expected grant should produce.
    task automatic tick(input logic ar, input logic lr, input logic fl, input logic pr,
                        input string tag);
        logic [37:0] e;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] d;
        @(negedge clk);
        chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(ar));
        chk({tag, ".lsu_ready"}, 64'(lsu_ready), 64'(lr));
        chk({tag, ".flush"}, 64'(flush), 64'(fl));
        chk({tag, ".wb_busy"}, 64'(wb_busy), 64'(fl));
        chk({tag, ".pc_redirect"}, 64'(pc_redirect), 64'(pr));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".rf_we"}, 64'(rf_we), 64'(e[37]));
            if (e[37]) begin
                chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(e[36:32]));
                chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(e[31:0]));
            end
        end
        rd = 5'd0;
        d  = 32'h0;
        if (ar) begin
            rd = alu_rd;
            d  = alu_result;
        end else if (lr) begin
            rd = lsu_rd;
            d  = lsu_result;
        end
        we = (ar || lr) && (rd != 5'd0);
        exp_q.push_back({we, rd, d});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rf_we", 64'(rf_we), 64'h0);
        chk("reset.rf_waddr", 64'(rf_waddr), 64'h0);
        chk("reset.rf_wdata", 64'(rf_wdata), 64'h0);
        chk("reset.pc_redirect", 64'(pc_redirect), 64'h0);
        chk("reset.pc_redirect_addr", 64'(pc_redirect_addr), 64'h0);
        chk("reset.flush", 64'(flush), 64'h0);
        chk("reset.wb_busy", 64'(wb_busy), 64'h0);
        rst_n = 1'b1;

        // ALU only
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, "alu_only");
        idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, "alu_only_wb");
        tick(1'b0, 1'b0, 1'b0, 1'b0, "idle");
        chk("hold.rf_waddr", 64'(rf_waddr), 64'h5);
        chk("hold.rf_wdata", 64'(rf_wdata), 64'h1234);

        // rd = 0 retires without a write; also leaves the pointer ALU-first
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd0, 32'hFFFF);
        tick(1'b0, 1'b1, 1'b0, 1'b0, "rd0");
        idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, "rd0_wb");
        chk("rd0.hold_waddr", 64'(rf_waddr), 64'h5);

        // Both valid for four cycles: ALU, LSU, ALU, LSU
        drive(1'b1, 5'd1, 32'hA, 1'b0, 32'h0, 1'b1, 5'd2, 32'hB);
        tick(1'b1, 1'b0, 1'b0, 1'b0, "rr0");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "rr1");
        tick(1'b1, 1'b0, 1'b0, 1'b0, "rr2");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "rr3");
        idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, "rr_wb");

        // Jump: redirect, two flush cycles, LSU retires during FLUSH
        drive(1'b1, 5'd1, 32'h104, 1'b1, 32'h200, 1'b0, 5'd0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, "jmp0");
        drive(1'b1, 5'd3, 32'h33, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("jmp1.pc_redirect_addr", 64'(pc_redirect_addr), 64'h200);
        tick(1'b0, 1'b0, 1'b1, 1'b1, "jmp1");
        drive(1'b1, 5'd3, 32'h33, 1'b0, 32'h0, 1'b1, 5'd4, 32'h44);
        tick(1'b0, 1'b1, 1'b1, 1'b0, "jmp2");
        drive(1'b1, 5'd3, 32'h33, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, "jmp3");
        idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, "jmp4");
        chk("jmp4.pc_redirect_addr_hold", 64'(pc_redirect_addr), 64'h200);

        // Reset asserted mid-FLUSH
        drive(1'b1, 5'd6, 32'h500, 1'b1, 32'h300, 1'b0, 5'd0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, "rjmp0");
        drive(1'b1, 5'd6, 32'h0, 1'b0, 32'h0, 1'b1, 5'd7, 32'h77);
        tick(1'b0, 1'b1, 1'b1, 1'b1, "rjmp1");
        idle();
        chk("rjmp2.pre_flush", 64'(flush), 64'h1);
        chk("rjmp2.pre_rf_we", 64'(rf_we), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst.flush", 64'(flush), 64'h0);
        chk("async_rst.pc_redirect", 64'(pc_redirect), 64'h0);
        chk("async_rst.rf_we", 64'(rf_we), 64'h0);
        chk("async_rst.wb_busy", 64'(wb_busy), 64'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 5'd9, 32'h99, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, "post_rst");
        idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, "post_rst_wb");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
